// File: rtl/instruction_loader.sv
// Byte-serial instruction loader: packs four bytes per word big-endian and writes them to
// instruction memory while holding the CPU. Define LOADER_OPCODE_CHECK_EN to reject illegal opcodes.
module instruction_loader (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [7:0]  WORD_COUNT,
  input  logic [7:0]  BYTE_IN,
  input  logic        BYTE_VALID,
  output logic        BYTE_READY,
  output logic [7:0]  IMEM_ADDR,
  output logic [31:0] IMEM_DATA,
  output logic        IMEM_WRITE,
  input  logic        IMEM_BUSY,
  output logic        CPU_HOLD,
  output logic        DONE,
  output logic        ERROR
);

  typedef enum logic [1:0] {StIdle, StCollect, StWrite, StFinish} state_e;

  state_e      state_q;
  logic [1:0]  byte_idx_q;
  logic [7:0]  word_count_q;
  logic        reject;

`ifdef LOADER_OPCODE_CHECK_EN
  function automatic logic opcode_legal(input logic [7:0] op);
    return (op <= 8'h07) || ((op >= 8'h0C) && (op <= 8'h10));
  endfunction

  // Only the first byte of each word carries the opcode.
  assign reject = (byte_idx_q == 2'd0) && !opcode_legal(BYTE_IN);
`else
  assign reject = 1'b0;
  assign ERROR  = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= StIdle;
      byte_idx_q   <= 2'd0;
      word_count_q <= 8'd0;
      BYTE_READY   <= 1'b0;
      IMEM_ADDR    <= 8'd0;
      IMEM_DATA    <= 32'd0;
      IMEM_WRITE   <= 1'b0;
      CPU_HOLD     <= 1'b0;
      DONE         <= 1'b0;
`ifdef LOADER_OPCODE_CHECK_EN
      ERROR        <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (START) begin
            DONE         <= 1'b0;
`ifdef LOADER_OPCODE_CHECK_EN
            ERROR        <= 1'b0;
`endif
            byte_idx_q   <= 2'd0;
            IMEM_ADDR    <= 8'd0;
            word_count_q <= WORD_COUNT;
            if (WORD_COUNT != 8'd0) begin
              state_q    <= StCollect;
              BYTE_READY <= 1'b1;
              CPU_HOLD   <= 1'b1;
            end else begin
              state_q    <= StFinish;
            end
          end
        end

        StCollect: begin
          if (BYTE_VALID && BYTE_READY) begin
            if (reject) begin
              // CPU stays held after an error until software restarts the load.
`ifdef LOADER_OPCODE_CHECK_EN
              ERROR      <= 1'b1;
`endif
              BYTE_READY <= 1'b0;
              state_q    <= StIdle;
            end else begin
              IMEM_DATA  <= {IMEM_DATA[23:0], BYTE_IN};
              byte_idx_q <= byte_idx_q + 2'd1;
              if (byte_idx_q == 2'd3) begin
                BYTE_READY <= 1'b0;
                IMEM_WRITE <= 1'b1;
                state_q    <= StWrite;
              end
            end
          end
        end

        StWrite: begin
          if (!IMEM_BUSY) begin
            IMEM_WRITE <= 1'b0;
            if (IMEM_ADDR == word_count_q - 8'd1) begin
              state_q <= StFinish;
            end else begin
              IMEM_ADDR  <= IMEM_ADDR + 8'd1;
              byte_idx_q <= 2'd0;
              BYTE_READY <= 1'b1;
              state_q    <= StCollect;
            end
          end
        end

        StFinish: begin
          DONE     <= 1'b1;
          CPU_HOLD <= 1'b0;
          state_q  <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: stimulus queues expected memory writes, a monitor
// pops and compares them as the DUT completes each write.
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  word_count = 8'd0;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        imem_write;
  logic        imem_busy = 1'b0;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;
  logic [39:0] exp_q[$];

  instruction_loader dut (
    .CLK       (clk),
    .RESET     (rst),
    .START     (start),
    .WORD_COUNT(word_count),
    .BYTE_IN   (byte_in),
    .BYTE_VALID(byte_valid),
    .BYTE_READY(byte_ready),
    .IMEM_ADDR (imem_addr),
    .IMEM_DATA (imem_data),
    .IMEM_WRITE(imem_write),
    .IMEM_BUSY (imem_busy),
    .CPU_HOLD  (cpu_hold),
    .DONE      (done),
    .ERROR     (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%08h required=%08h", name, act, req);
    end
  endtask

  // Monitor: a write completes on the next edge when IMEM_WRITE is high and IMEM_BUSY low.
  initial begin
    logic [39:0] e;
    forever begin
      @(negedge clk);
      if (!rst && imem_write && !imem_busy) begin
        n_writes++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", {24'd0, imem_addr}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", {24'd0, imem_addr}, {24'd0, e[39:32]});
          check("write_data", imem_data, e[31:0]);
        end
      end
    end
  end

  task automatic do_start(input logic [7:0] wc);
    @(negedge clk);
    start = 1'b1;
    word_count = wc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n = 0;
    @(negedge clk);
    byte_in = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("byte_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 byte_valid = 1'b0;
    if (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
    check({tag, "_imem_addr"}, {24'd0, imem_addr}, 32'd0);
    check({tag, "_imem_data"}, imem_data, 32'd0);
    check({tag, "_imem_write"}, {31'd0, imem_write}, 32'd0);
    check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
  endtask

  initial begin
    int w0;
    int hi;
    logic [7:0]  a_hold;
    logic [31:0] d_hold;

    #2 check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Two words, back-to-back bytes; first byte of word 1 waits out the write.
    w0 = n_writes;
    exp_q.push_back({8'd0, 32'h0004_0005});
    exp_q.push_back({8'd1, 32'h0201_0204});
    do_start(8'd2);
    check("hold_after_start", {31'd0, cpu_hold}, 32'd1);
    check("ready_after_start", {31'd0, byte_ready}, 32'd1);
    send_word(32'h0004_0005, 1'b0);
    send_word(32'h0201_0204, 1'b0);
    wait_done("two_word_done");
    check("two_word_hold", {31'd0, cpu_hold}, 32'd0);
    check("two_word_count", n_writes - w0, 32'd2);

    // Valid toggling every cycle, plus a START during COLLECT that must be ignored.
    w0 = n_writes;
    exp_q.push_back({8'd0, 32'h0D03_0102});
    do_start(8'd1);
    check("done_cleared", {31'd0, done}, 32'd0);
    do_start(8'd3);
    send_word(32'h0D03_0102, 1'b1);
    wait_done("toggle_done");
    check("toggle_count", n_writes - w0, 32'd1);

    // Five busy cycles stretch the write to six cycles.
    w0 = n_writes;
    @(posedge clk);
    #1 imem_busy = 1'b1;
    exp_q.push_back({8'd0, 32'h0C0A_0B01});
    do_start(8'd1);
    send_word(32'h0C0A_0B01, 1'b0);
    a_hold = imem_addr;
    d_hold = imem_data;
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (imem_write) begin
        hi++;
        check("busy_addr_stable", {24'd0, imem_addr}, {24'd0, a_hold});
        check("busy_data_stable", imem_data, d_hold);
        check("busy_ready_low", {31'd0, byte_ready}, 32'd0);
      end
      @(posedge clk);
      #1;
      if (i == 4) imem_busy = 1'b0;
    end
    check("busy_write_cycles", hi, 32'd6);
    check("busy_data_value", d_hold, 32'h0C0A_0B01);
    wait_done("busy_done");
    check("busy_count", n_writes - w0, 32'd1);

    // Zero-length load: FINISH on the first edge, DONE one edge later.
    w0 = n_writes;
    do_start(8'd0);
    check("zero_done_early", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1 check("zero_done_late", {31'd0, done}, 32'd1);
    check("zero_no_write", n_writes - w0, 32'd0);
    check("zero_hold", {31'd0, cpu_hold}, 32'd0);

    // Opcode 0x08 is rejected only when validation is compiled in.
    w0 = n_writes;
`ifdef LOADER_OPCODE_CHECK_EN
    do_start(8'd1);
    send_byte(8'h08, 1'b0);
    repeat (3) @(negedge clk);
    check("illegal_error", {31'd0, error}, 32'd1);
    check("illegal_hold", {31'd0, cpu_hold}, 32'd1);
    check("illegal_ready", {31'd0, byte_ready}, 32'd0);
    check("illegal_done", {31'd0, done}, 32'd0);
    check("illegal_no_write", n_writes - w0, 32'd0);
`else
    exp_q.push_back({8'd0, 32'h0811_2233});
    do_start(8'd1);
    send_word(32'h0811_2233, 1'b0);
    wait_done("opcode08_done");
    check("opcode08_error", {31'd0, error}, 32'd0);
    check("opcode08_count", n_writes - w0, 32'd1);
`endif

    // Reset two bytes into the second word, then a fresh session from address 0.
    w0 = n_writes;
    exp_q.push_back({8'd0, 32'h0102_0304});
    do_start(8'd2);
    send_word(32'h0102_0304, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h06, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1 check_reset_outputs("midreset");
    check("midreset_writes", n_writes - w0, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    w0 = n_writes;
    exp_q.push_back({8'd0, 32'h0506_0708});
    do_start(8'd1);
    send_word(32'h0506_0708, 1'b0);
    wait_done("after_reset_done");
    check("after_reset_count", n_writes - w0, 32'd1);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1);
  end

endmodule
